// File: rtl/avalon_multi_interval_timer.sv
// Avalon-MM slave with NUM_CH independent interval down-counters and per-channel IRQs.
// Optional macro TIMER_TICK_OUT_EN adds a registered per-channel tick pulse output.
module avalon_multi_interval_timer #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_PERIOD = 49999,
    parameter int unsigned RUN_AT_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [5:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
`ifdef TIMER_TICK_OUT_EN
    ,
    output logic [NUM_CH-1:0] tick
`endif
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } run_state_e;

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_CONTROL = 3'd1,
        REG_PERIOD  = 3'd2,
        REG_SNAP    = 3'd3,
        REG_PEND    = 3'd4
    } reg_e;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);
    localparam run_state_e       RST_STATE  = (RUN_AT_RESET != 0) ? ST_RUNNING : ST_STOPPED;

    logic       wr_en;
    logic [2:0] ch_sel;
    reg_e       reg_sel;

    assign wr_en   = chipselect & ~write_n;
    assign ch_sel  = address[5:3];
    assign reg_sel = reg_e'(address[2:0]);

    // Per-channel readback views gathered for the shared read mux.
    logic [CNT_W-1:0] period_rb [NUM_CH];
    logic [CNT_W-1:0] snap_rb   [NUM_CH];
    logic [1:0]       status_rb [NUM_CH];
    logic [1:0]       ctrl_rb   [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             ch_wr;
        logic             wr_status;
        logic             wr_ctrl;
        logic             wr_period;
        logic             wr_snap;
        logic             start;
        logic             stop;
        logic             timeout;

        run_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] snap_q, snap_d;
        logic             to_q, to_d;
        logic             ito_q, ito_d;
        logic             cont_q, cont_d;

        assign ch_wr     = wr_en && (ch_sel == 3'(g));
        assign wr_status = ch_wr && (reg_sel == REG_STATUS);
        assign wr_ctrl   = ch_wr && (reg_sel == REG_CONTROL);
        assign wr_period = ch_wr && (reg_sel == REG_PERIOD);
        assign wr_snap   = ch_wr && (reg_sel == REG_SNAP);
        assign start     = wr_ctrl && writedata[2];
        assign stop      = wr_ctrl && writedata[3];

        // A PERIOD load or START/STOP strobe overrides the count, so no event that cycle.
        assign timeout = (state_q == ST_RUNNING) && (cnt_q == '0)
                         && !wr_period && !start && !stop;

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            period_d = period_q;
            snap_d   = snap_q;
            to_d     = to_q;
            ito_d    = ito_q;
            cont_d   = cont_q;

            if (wr_ctrl) begin
                ito_d  = writedata[0];
                cont_d = writedata[1];
            end

            if (wr_period) begin
                period_d = writedata[CNT_W-1:0];
                cnt_d    = writedata[CNT_W-1:0];
            end else if (stop) begin
                state_d = ST_STOPPED;
            end else if (start) begin
                state_d = ST_RUNNING;
                cnt_d   = period_q;
            end else begin
                case (state_q)
                    ST_RUNNING: begin
                        if (timeout) begin
                            cnt_d = period_q;
                            if (!cont_q) begin
                                state_d = ST_STOPPED;
                            end
                        end else begin
                            cnt_d = cnt_q - ONE;
                        end
                    end
                    default: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end

            if (wr_snap) begin
                snap_d = cnt_q;
            end

            if (timeout) begin
                to_d = 1'b1;
            end else if (wr_status) begin
                to_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q  <= RST_STATE;
                cnt_q    <= RST_PERIOD;
                period_q <= RST_PERIOD;
                snap_q   <= '0;
                to_q     <= 1'b0;
                ito_q    <= 1'b0;
                cont_q   <= 1'b1;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                period_q <= period_d;
                snap_q   <= snap_d;
                to_q     <= to_d;
                ito_q    <= ito_d;
                cont_q   <= cont_d;
            end
        end

        assign irq_vec[g]   = to_q & ito_q;
        assign period_rb[g] = period_q;
        assign snap_rb[g]   = snap_q;
        assign status_rb[g] = {(state_q == ST_RUNNING), to_q};
        assign ctrl_rb[g]   = {cont_q, ito_q};

`ifdef TIMER_TICK_OUT_EN
        logic tick_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= timeout;
            end
        end

        assign tick[g] = tick_q;
`endif
    end

    assign irq = |irq_vec;

    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_sel == 3'(i)) begin
                case (reg_sel)
                    REG_STATUS:  rdata_d[1:0]        = status_rb[i];
                    REG_CONTROL: rdata_d[1:0]        = ctrl_rb[i];
                    REG_PERIOD:  rdata_d[CNT_W-1:0]  = period_rb[i];
                    REG_SNAP:    rdata_d[CNT_W-1:0]  = snap_rb[i];
                    REG_PEND:    rdata_d[NUM_CH-1:0] = irq_vec;
                    default:     rdata_d             = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;

endmodule

// File: doc/avalon_multi_interval_timer.md
Name: avalon_multi_interval_timer

Overview:
Parametrised successor to the single 1 ms interval timer: NUM_CH independent down-counters behind one Avalon-MM slave. Each channel has CNT_W-bit period and snapshot registers, continuous or one-shot mode, and software start/stop. Used for the 1 ms system tick plus extra per-feature timeouts in the Qsys system. Per-channel and combined IRQ outputs go to the processor interrupt controller.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 32, counter/period/snapshot width (8..32)
RESET_PERIOD, 49999, period and counter value at reset (1 ms at 50 MHz, period+1 cycles)
RUN_AT_RESET, 1, 1 = all channels run continuously out of reset; 0 = stopped

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
address  in  6  [5:3] channel index, [2:0] register index
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  OR of irq_vec
irq_vec  out  NUM_CH  per-channel interrupt = TO & ITO

Behaviour:
- Register map per channel (reg index):
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO (rw), bit1 CONT (rw), bit2 START (write-1 strobe, reads 0), bit3 STOP (write-1 strobe, reads 0).
  - 2 PERIOD: rw, CNT_W bits, zero-extended.
  - 3 SNAP: any write captures the live counter; read returns the captured value.
  - 4 PEND: read-only, bit i = irq_vec[i], same value in every channel slot.
  - 5..7: read 0.
- Channel index >= NUM_CH: reads 0, writes ignored.
- Write accepted when chipselect & ~write_n; no wait states.
- Read: readdata updates on every clk edge from the addressed register, so 1-cycle latency.
- Reset values (all channels):
  - counter = period = RESET_PERIOD; RUN = RUN_AT_RESET; CONT = 1; ITO = 0; TO = 0; snapshot = 0.
  - readdata = 0; irq = 0; irq_vec = 0.
- Counting while RUN = 1:
  - count > 0: count decrements by 1.
  - count == 0: timeout event. TO set next edge, counter reloads from PERIOD.
  - On timeout, CONT = 1 keeps RUN = 1; CONT = 0 clears RUN (one-shot).
  - Period P therefore gives one event every P+1 cycles.
  - P = 0 in continuous mode: event every cycle, TO stays set.
- While RUN = 0: counter holds its value; no events.
- PERIOD write: period and counter both load writedata[CNT_W-1:0] on the same edge. Overrides decrement/reload that cycle and suppresses any timeout that cycle. RUN is unchanged.
- START: counter reloads from PERIOD, RUN = 1. START while already running restarts the count.
- STOP: RUN = 0, counter frozen.
- START and STOP in the same write: STOP wins.
- Simultaneous-event priority:
  - Timeout event and STATUS write in the same cycle: TO = 1 (set wins; no lost events).
  - SNAP write in a timeout cycle captures 0.
- irq_vec[i] is combinational from registered TO and ITO. Clearing ITO deasserts the IRQ immediately without clearing TO.
- Asynchronous reset mid-count returns every channel to reset values at once.
- Channels are fully independent; a write to one never affects another.

Optional Feature:
TIMER_TICK_OUT_EN:
- Defined: adds output port tick [NUM_CH-1:0]. tick[i] is a one-cycle registered pulse on the same edge TO[i] is set, regardless of ITO. It is also pulsed when TO is already set. Intended for hardware consumers such as the data-transmission scheduler.
- Not defined: port absent, no extra logic.

Test Plan:
- Reset, no writes -> ch0 TO rises after 50000 cycles, again 50000 cycles later. irq stays 0 until ch0 CONTROL = 0x1, then irq = 1. STATUS write clears it.
- ch1 PERIOD = 9, CONTROL = 0x4 (START, CONT = 0, one-shot) -> exactly one event 10 cycles later. STATUS reads 0x1 (TO = 1, RUN = 0); counter holds 9.
- ch2 running, CONTROL = 0x8 (STOP) -> counter frozen. SNAP write then read returns the same value on two reads 100 cycles apart.
- STATUS write issued on the exact cycle ch0 counter == 0 -> TO remains 1. PEND bit0 = 1 if ITO set.
- PERIOD write of 5 on the cycle count == 0 -> no timeout that cycle; next event 6 cycles later.
- Read address 0x3C (channel 7) with NUM_CH = 4 -> readdata = 0 one cycle later; write there changes no channel.
